// File: rtl/ex_hazard_if.sv
// ----------------------------------------------------------------------------
// ex_hazard_if
//   Bundle between the RV32I pipeline datapath and the hazard/forwarding
//   sequencer (ex_hazard_ctrl).
//
//   Handshake semantics: there is no valid/ready pair here. Every signal is
//   sampled on each rising clock edge. id_valid qualifies the ID-stage fields,
//   and mem_stall acts as a global "not ready": while it is high, no pipeline
//   register advances.
//
//   master : the pipeline side. It drives the ID fields, ex_redirect and
//            mem_stall, and consumes the control outputs.
//   slave  : the hazard controller.
//
//   Signals
//     id_valid, id_rs1, id_rs2, id_use_a_rs1, id_use_b_rs2,
//     id_rd, id_regwrite, id_is_load          ID-stage instruction info
//     ex_redirect                             taken branch/jump resolved in EX
//     mem_stall                               memory not ready, hold the pipe
//     alumux1_fw, alumux2_fw                  registered EX operand selects
//                                             (00 idex, 01 exmem, 10 memwb)
//     stall_front, bubble_ex, flush_front,
//     freeze_all                              pipeline register controls
//     stall_cnt, flush_cnt                    performance counters
//     fsm_state                               sequencer state (debug)
// ----------------------------------------------------------------------------
interface ex_hazard_if #(
    parameter int REGW = 5,
    parameter int CNTW = 32
);
    logic            id_valid;
    logic [REGW-1:0] id_rs1;
    logic [REGW-1:0] id_rs2;
    logic            id_use_a_rs1;
    logic            id_use_b_rs2;
    logic [REGW-1:0] id_rd;
    logic            id_regwrite;
    logic            id_is_load;
    logic            ex_redirect;
    logic            mem_stall;

    logic [1:0]      alumux1_fw;
    logic [1:0]      alumux2_fw;
    logic            stall_front;
    logic            bubble_ex;
    logic            flush_front;
    logic            freeze_all;
    logic [CNTW-1:0] stall_cnt;
    logic [CNTW-1:0] flush_cnt;
    logic [1:0]      fsm_state;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_a_rs1, id_use_b_rs2,
               id_rd, id_regwrite, id_is_load, ex_redirect, mem_stall,
        input  alumux1_fw, alumux2_fw, stall_front, bubble_ex, flush_front,
               freeze_all, stall_cnt, flush_cnt, fsm_state
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_a_rs1, id_use_b_rs2,
               id_rd, id_regwrite, id_is_load, ex_redirect, mem_stall,
        output alumux1_fw, alumux2_fw, stall_front, bubble_ex, flush_front,
               freeze_all, stall_cnt, flush_cnt, fsm_state
    );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// ex_hazard_ctrl
//   Hazard and forwarding sequencer for the 5-stage RV32I pipeline.
//
//   The block keeps shadow copies of the instructions in EX and MEM: valid, rd,
//   regwrite, and, for EX, is_load. From these it does four things:
//     - It computes the EX operand forward selects one cycle early, in ID, and
//       registers them.
//     - It detects load-use hazards and inserts a single bubble.
//     - It squashes the front end on a redirect from EX.
//     - It freezes everything on a memory stall.
//
//   Ports
//     clk  clock
//     rst  synchronous reset, active-high
//     hz   ex_hazard_if.slave (the ID info and pipe controls; see the interface)
//
//   Control priority: rst > mem_stall > ex_redirect > load-use > advance.
// ----------------------------------------------------------------------------
module ex_hazard_ctrl #(
    parameter int REGW = 5,
    parameter int CNTW = 32
) (
    input  logic     clk,
    input  logic     rst,
    ex_hazard_if.slave hz
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    // regwrite is stored pre-qualified with valid and rd != 0, so a match
    // against it never needs to re-check those.
    typedef struct packed {
        logic            valid;
        logic [REGW-1:0] rd;
        logic            regwrite;
        logic            is_load;
    } ex_slot_t;

    typedef struct packed {
        logic            valid;
        logic [REGW-1:0] rd;
        logic            regwrite;
    } mem_slot_t;

    localparam logic [1:0] FW_IDEX  = 2'b00;
    localparam logic [1:0] FW_EXMEM = 2'b01;
    localparam logic [1:0] FW_MEMWB = 2'b10;

    ex_slot_t        ex_q,  ex_d,  id_slot;
    mem_slot_t       mem_q, mem_d;
    state_t          state_q, state_d;
    state_t          prev_q,  prev_d;
    state_t          eff_state;
    logic [1:0]      fwa_q, fwa_d, fwb_q, fwb_d;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNTW-1:0] flush_cnt_q, flush_cnt_d;

    logic uses_a, uses_b;
    logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
    logic load_use, lu_take, flush_take, freeze, bubble;

    // Operand actually reads a register. x0 never needs forwarding.
    assign uses_a = hz.id_use_a_rs1 && (hz.id_rs1 != '0);
    assign uses_b = hz.id_use_b_rs2 && (hz.id_rs2 != '0);

    assign ex_hit_a  = uses_a && ex_q.regwrite  && (ex_q.rd  == hz.id_rs1);
    assign ex_hit_b  = uses_b && ex_q.regwrite  && (ex_q.rd  == hz.id_rs2);
    assign mem_hit_a = uses_a && mem_q.valid && mem_q.regwrite && (mem_q.rd == hz.id_rs1);
    assign mem_hit_b = uses_b && mem_q.valid && mem_q.regwrite && (mem_q.rd == hz.id_rs2);

    // While frozen, the state the pipe will resume in is the one saved on entry.
    assign eff_state = (state_q == ST_MEM_WAIT) ? prev_q : state_q;

    // A load in EX whose result the ID instruction needs. Limit this to one
    // bubble per load: in LU_STALL the load has already moved on to MEM.
    assign load_use = hz.id_valid && ex_q.valid && ex_q.is_load && (ex_q.rd != '0)
                   && ((hz.id_use_a_rs1 && (ex_q.rd == hz.id_rs1)) ||
                       (hz.id_use_b_rs2 && (ex_q.rd == hz.id_rs2)))
                   && (eff_state != ST_LU_STALL);

    assign freeze     = !rst && hz.mem_stall;
    assign flush_take = !rst && !hz.mem_stall && hz.ex_redirect;
    // A redirect squashes the ID instruction, so its load-use stall is moot.
    assign lu_take    = !rst && !hz.mem_stall && !hz.ex_redirect && load_use;
    assign bubble     = flush_take || lu_take;

    assign hz.freeze_all  = freeze;
    assign hz.flush_front = flush_take;
    assign hz.stall_front = lu_take;
    assign hz.bubble_ex   = bubble;
    assign hz.alumux1_fw  = fwa_q;
    assign hz.alumux2_fw  = fwb_q;
    assign hz.stall_cnt   = stall_cnt_q;
    assign hz.flush_cnt   = flush_cnt_q;
    assign hz.fsm_state   = state_q;

    always_comb begin
        id_slot.valid    = hz.id_valid;
        id_slot.rd       = hz.id_rd;
        id_slot.regwrite = hz.id_valid && hz.id_regwrite && (hz.id_rd != '0);
        id_slot.is_load  = hz.id_valid && hz.id_is_load;

        ex_d        = ex_q;
        mem_d       = mem_q;
        fwa_d       = fwa_q;
        fwb_d       = fwb_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        state_d     = state_q;
        prev_d      = prev_q;

        if (hz.mem_stall) begin
            // Remember where to resume. A frozen cycle changes nothing else.
            if (state_q != ST_MEM_WAIT) begin
                prev_d  = state_q;
                state_d = ST_MEM_WAIT;
            end
        end else begin
            mem_d.valid    = ex_q.valid;
            mem_d.rd       = ex_q.rd;
            mem_d.regwrite = ex_q.regwrite;
            ex_d           = bubble ? '0 : id_slot;

            // The EX occupant is about to move to EX/MEM, and the MEM occupant
            // to MEM/WB. The nearer producer carries the newer value, so it wins.
            if (bubble || !hz.id_valid) begin
                fwa_d = FW_IDEX;
                fwb_d = FW_IDEX;
            end else begin
                fwa_d = ex_hit_a ? FW_EXMEM : (mem_hit_a ? FW_MEMWB : FW_IDEX);
                fwb_d = ex_hit_b ? FW_EXMEM : (mem_hit_b ? FW_MEMWB : FW_IDEX);
            end

            if (lu_take)    stall_cnt_d = stall_cnt_q + CNTW'(1);
            if (flush_take) flush_cnt_d = flush_cnt_q + CNTW'(1);
            state_d = lu_take ? ST_LU_STALL : ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            fwa_q       <= FW_IDEX;
            fwb_q       <= FW_IDEX;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            state_q     <= ST_RUN;
            prev_q      <= ST_RUN;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            fwa_q       <= fwa_d;
            fwb_q       <= fwb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            state_q     <= state_d;
            prev_q      <= prev_d;
        end
    end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ex_hazard_ctrl
//   Bench for ex_hazard_ctrl. It drives one ID-stage instruction per cycle on
//   the falling edge. The expected control outputs for that cycle, and the
//   expected forward selects after the next rising edge, are pushed to queues
//   as each instruction is driven. They are popped and compared when the DUT
//   presents them.
//   ctl code: {stall_front, bubble_ex, flush_front, freeze_all}
//   sel code: {alumux1_fw, alumux2_fw}
// ----------------------------------------------------------------------------
module tb_ex_hazard_ctrl;
    localparam int REGW = 5;
    localparam int CNTW = 32;

    typedef struct packed {
        logic            v;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic            ua;
        logic            ub;
        logic [REGW-1:0] rd;
        logic            rw;
        logic            ld;
    } ins_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   step     = 0;

    logic [3:0] exp_ctl_q[$];
    logic [3:0] exp_sel_q[$];

    ex_hazard_if #(.REGW(REGW), .CNTW(CNTW)) hz ();

    ex_hazard_ctrl #(.REGW(REGW), .CNTW(CNTW)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (step %0d): got %0h expected %0h", tag, step, got, exp);
        end
    endtask

    // ---------------- instruction helpers ----------------
    function automatic ins_t f_nop();
        ins_t i;
        i = '0;
        return i;
    endfunction

    function automatic ins_t f_alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        ins_t i;
        i = '{v: 1'b1, rs1: rs1, rs2: rs2, ua: 1'b1, ub: 1'b1, rd: rd, rw: 1'b1, ld: 1'b0};
        return i;
    endfunction

    function automatic ins_t f_lw(input logic [4:0] rd, input logic [4:0] rs1);
        ins_t i;
        i = '{v: 1'b1, rs1: rs1, rs2: 5'd0, ua: 1'b1, ub: 1'b0, rd: rd, rw: 1'b1, ld: 1'b1};
        return i;
    endfunction

    // ---------------- driver ----------------
    task automatic apply(input ins_t i);
        hz.id_valid     = i.v;
        hz.id_rs1       = i.rs1;
        hz.id_rs2       = i.rs2;
        hz.id_use_a_rs1 = i.ua;
        hz.id_use_b_rs2 = i.ub;
        hz.id_rd        = i.rd;
        hz.id_regwrite  = i.rw;
        hz.id_is_load   = i.ld;
    endtask

    task automatic drive(input ins_t i, input logic redir, input logic mstall,
                         input logic [3:0] ectl, input logic [3:0] esel);
        logic [3:0] e;
        @(negedge clk);
        step++;
        apply(i);
        hz.ex_redirect = redir;
        hz.mem_stall   = mstall;
        exp_ctl_q.push_back(ectl);
        exp_sel_q.push_back(esel);
        #1;
        e = exp_ctl_q.pop_front();
        check_eq("ctl", {28'd0, hz.stall_front, hz.bubble_ex, hz.flush_front, hz.freeze_all}, {28'd0, e});
        @(posedge clk);
        #1;
        e = exp_sel_q.pop_front();
        check_eq("sel", {28'd0, hz.alumux1_fw, hz.alumux2_fw}, {28'd0, e});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        ins_t t;

        // T1: reset with random inputs
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            t = '{v: 1'($urandom_range(0, 1)), rs1: 5'($urandom_range(0, 31)),
                  rs2: 5'($urandom_range(0, 31)), ua: 1'($urandom_range(0, 1)),
                  ub: 1'($urandom_range(0, 1)), rd: 5'($urandom_range(0, 31)),
                  rw: 1'($urandom_range(0, 1)), ld: 1'($urandom_range(0, 1))};
            apply(t);
            hz.ex_redirect = 1'($urandom_range(0, 1));
            hz.mem_stall   = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
        check_eq("rst_ctl", {28'd0, hz.stall_front, hz.bubble_ex, hz.flush_front, hz.freeze_all}, 32'd0);
        check_eq("rst_sel", {28'd0, hz.alumux1_fw, hz.alumux2_fw}, 32'd0);
        check_eq("rst_stall_cnt", hz.stall_cnt, 32'd0);
        check_eq("rst_flush_cnt", hz.flush_cnt, 32'd0);
        check_eq("rst_state", {30'd0, hz.fsm_state}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        apply(f_nop());
        hz.ex_redirect = 1'b0;
        hz.mem_stall   = 1'b0;

        // T2: EX->EX forwarding
        drive(f_alu(5, 1, 2), 0, 0, 4'b0000, 4'b0000);
        drive(f_alu(6, 5, 5), 0, 0, 4'b0000, 4'b0101);
        drive(f_nop(),        0, 0, 4'b0000, 4'b0000);
        drive(f_nop(),        0, 0, 4'b0000, 4'b0000);

        // T3: MEM->EX forwarding, EX/MEM priority, operand A not using rs1
        drive(f_alu(5, 1, 2), 0, 0, 4'b0000, 4'b0000);
        drive(f_nop(),        0, 0, 4'b0000, 4'b0000);
        drive(f_alu(7, 5, 1), 0, 0, 4'b0000, 4'b1000);
        drive(f_alu(5, 1, 2), 0, 0, 4'b0000, 4'b0000);
        drive(f_alu(5, 5, 2), 0, 0, 4'b0000, 4'b0100);
        drive(f_alu(8, 5, 5), 0, 0, 4'b0000, 4'b0101);
        t = f_alu(9, 8, 8);
        t.ua = 1'b0;
        drive(t,              0, 0, 4'b0000, 4'b0001);
        drive(f_nop(),        0, 0, 4'b0000, 4'b0000);
        drive(f_nop(),        0, 0, 4'b0000, 4'b0000);
        check_eq("t3_stall_cnt", hz.stall_cnt, 32'd0);

        // T4: load-use, then lw x0 followed by a use of x0
        drive(f_lw(3, 1),     0, 0, 4'b0000, 4'b0000);
        drive(f_alu(4, 3, 2), 0, 0, 4'b1100, 4'b0000);
        check_eq("t4_stall_cnt", hz.stall_cnt, 32'd1);
        check_eq("t4_state_lu", {30'd0, hz.fsm_state}, 32'd1);
        drive(f_alu(4, 3, 2), 0, 0, 4'b0000, 4'b1000);
        check_eq("t4_stall_once", hz.stall_cnt, 32'd1);
        drive(f_nop(),        0, 0, 4'b0000, 4'b0000);
        drive(f_nop(),        0, 0, 4'b0000, 4'b0000);
        drive(f_lw(0, 1),     0, 0, 4'b0000, 4'b0000);
        drive(f_alu(4, 0, 0), 0, 0, 4'b0000, 4'b0000);
        check_eq("t4_x0_stall_cnt", hz.stall_cnt, 32'd1);
        drive(f_nop(),        0, 0, 4'b0000, 4'b0000);
        drive(f_nop(),        0, 0, 4'b0000, 4'b0000);

        // T5: redirect in the same cycle as a load-use match
        drive(f_lw(3, 1),     0, 0, 4'b0000, 4'b0000);
        drive(f_alu(4, 3, 2), 1, 0, 4'b0110, 4'b0000);
        check_eq("t5_flush_cnt", hz.flush_cnt, 32'd1);
        check_eq("t5_stall_cnt", hz.stall_cnt, 32'd1);
        drive(f_nop(),        0, 0, 4'b0000, 4'b0000);
        drive(f_nop(),        0, 0, 4'b0000, 4'b0000);

        // T6: mem_stall for 5 cycles in the middle of a load-use
        drive(f_alu(5, 1, 2), 0, 0, 4'b0000, 4'b0000);
        drive(f_lw(3, 5),     0, 0, 4'b0000, 4'b0100);
        for (int c = 0; c < 5; c++) begin
            drive(f_alu(4, 3, 2), 0, 1, 4'b0001, 4'b0100);
            check_eq("t6_frz_stall_cnt", hz.stall_cnt, 32'd1);
            check_eq("t6_frz_flush_cnt", hz.flush_cnt, 32'd1);
            check_eq("t6_frz_state", {30'd0, hz.fsm_state}, 32'd2);
        end
        drive(f_alu(4, 3, 2), 0, 0, 4'b1100, 4'b0000);
        check_eq("t6_stall_cnt", hz.stall_cnt, 32'd2);
        drive(f_alu(4, 3, 2), 0, 0, 4'b0000, 4'b1000);
        drive(f_nop(),        0, 0, 4'b0000, 4'b0000);
        check_eq("t6_stall_once", hz.stall_cnt, 32'd2);

        // Redirect presented during a freeze takes effect only once released
        drive(f_nop(),        1, 1, 4'b0001, 4'b0000);
        check_eq("frz_redir_flush_cnt", hz.flush_cnt, 32'd1);
        drive(f_nop(),        1, 0, 4'b0110, 4'b0000);
        check_eq("redir_flush_cnt", hz.flush_cnt, 32'd2);
        drive(f_nop(),        0, 0, 4'b0000, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
